// File: rtl/ssd_sched_pkg.sv
// Shared definitions for the SSD display scheduler.
// Holds the FSM state encoding, SSD register offsets, the "no owner" code,
// the AHB-Lite constant encodings and a helper that builds the preemption
// mask for the fixed-priority arbiter.
package ssd_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr0,
      StAddr1Data0,
      StData1,
      StHold
   } state_e;

   // SSD slave register map, relative to the slave base address.
   localparam logic [31:0] DATA_OFS = 32'h0000_0000;
   localparam logic [31:0] DONE_OFS = 32'h0000_0004;

   localparam logic [1:0] OWNER_NONE = 2'd3;

   // AHB-Lite encodings.
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;

   // Requesters allowed to preempt the given owner: strictly lower indices.
   function automatic logic [2:0] higher_prio_mask(input logic [1:0] owner);
      logic [2:0] mask;
      case (owner)
         2'd0:    mask = 3'b000;
         2'd1:    mask = 3'b001;
         2'd2:    mask = 3'b011;
         default: mask = 3'b111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/prio_arb3.sv
// Combinational three-way fixed-priority arbiter, lowest index wins.
// Ports:
//   req_i   - request vector
//   mask_i  - per-requester enable; cleared bits cannot win
//   gnt_o   - one-hot grant (zero when nothing eligible)
//   idx_o   - index of the winner (0 when nothing eligible)
//   valid_o - some eligible request is present
module prio_arb3 (
   input  logic [2:0] req_i,
   input  logic [2:0] mask_i,
   output logic [2:0] gnt_o,
   output logic [1:0] idx_o,
   output logic       valid_o
);

   logic [2:0] masked;

   always_comb begin
      masked  = req_i & mask_i;
      gnt_o   = 3'b000;
      idx_o   = 2'd0;
      valid_o = |masked;
      if (masked[0]) begin
         gnt_o = 3'b001;
         idx_o = 2'd0;
      end else if (masked[1]) begin
         gnt_o = 3'b010;
         idx_o = 2'd1;
      end else if (masked[2]) begin
         gnt_o = 3'b100;
         idx_o = 2'd2;
      end
   end

endmodule

// File: rtl/ssd_disp_sched.sv
// Seven-segment display scheduler.
// Arbitrates three display requesters (fixed priority, lower index wins),
// writes the winning 5-bit value to the SSD slave over AHB-Lite (data
// register then done flag, two pipelined NONSEQ beats), then keeps the value
// on display for HOLD_CYCLES cycles. Only a strictly higher-priority
// requester may cut a hold short.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   req_valid_i/data_i  - per-requester request and 5-bit value
//   req_ready_o         - one-hot acceptance strobe
//   ahb_m_*             - AHB-Lite master towards the SSD slave
//   disp_value_o        - last value whose write sequence completed
//   owner_o             - current display owner, 3 = none
//   busy_o              - FSM not idle
module ssd_disp_sched
   import ssd_sched_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter logic [31:0] BASE_ADDR   = 32'hD000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req_valid_i,
   input  logic [14:0] req_data_i,
   output logic [2:0]  req_ready_o,
   output logic [31:0] ahb_m_haddr_o,
   output logic [1:0]  ahb_m_htrans_o,
   output logic        ahb_m_hwrite_o,
   output logic [2:0]  ahb_m_hsize_o,
   output logic [2:0]  ahb_m_hburst_o,
   output logic [3:0]  ahb_m_hprot_o,
   output logic        ahb_m_hmastlock_o,
   output logic [31:0] ahb_m_hwdata_o,
   input  logic        ahb_m_hready_i,
   output logic [4:0]  disp_value_o,
   output logic [1:0]  owner_o,
   output logic        busy_o
);

   localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

   state_e            state_q, state_d;
   logic [4:0]        data_q, data_d;
   logic [1:0]        owner_q, owner_d;
   logic [4:0]        disp_q, disp_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [2:0] arb_mask, arb_gnt;
   logic [1:0] arb_idx;
   logic       arb_valid, grant_ok;
   logic [4:0] arb_data;

   // Arbitration only happens in IDLE and HOLD; in HOLD only preemptors count.
   always_comb begin
      arb_mask = 3'b000;
      if (state_q == StIdle) begin
         arb_mask = 3'b111;
      end else if (state_q == StHold) begin
         arb_mask = higher_prio_mask(owner_q);
      end
   end

   prio_arb3 u_arb (
      .req_i   (req_valid_i),
      .mask_i  (arb_mask),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // No acceptance is signalled while reset is asserted.
   assign grant_ok = arb_valid & ~reset;

   always_comb begin
      case (arb_idx)
         2'd0:    arb_data = req_data_i[4:0];
         2'd1:    arb_data = req_data_i[9:5];
         default: arb_data = req_data_i[14:10];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      owner_d     = owner_q;
      disp_d      = disp_q;
      cnt_d       = cnt_q;
      req_ready_o = 3'b000;
      case (state_q)
         StIdle: begin
            if (grant_ok) begin
               req_ready_o = arb_gnt;
               data_d      = arb_data;
               owner_d     = arb_idx;
               state_d     = StAddr0;
            end
         end
         StAddr0: begin
            if (ahb_m_hready_i) state_d = StAddr1Data0;
         end
         StAddr1Data0: begin
            if (ahb_m_hready_i) state_d = StData1;
         end
         StData1: begin
            if (ahb_m_hready_i) begin
               disp_d  = data_q;
               cnt_d   = CntW'(HOLD_CYCLES - 1);
               state_d = StHold;
            end
         end
         StHold: begin
            if (grant_ok) begin
               req_ready_o = arb_gnt;
               data_d      = arb_data;
               owner_d     = arb_idx;
               state_d     = StAddr0;
            end else if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         data_q  <= '0;
         owner_q <= OWNER_NONE;
         disp_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         owner_q <= owner_d;
         disp_q  <= disp_d;
         cnt_q   <= cnt_d;
      end
   end

   // Bus outputs decode straight from state, so a stalled beat holds steady.
   always_comb begin
      ahb_m_htrans_o = HTRANS_IDLE;
      ahb_m_haddr_o  = BASE_ADDR + DATA_OFS;
      ahb_m_hwdata_o = 32'h0;
      case (state_q)
         StAddr0: begin
            ahb_m_htrans_o = HTRANS_NONSEQ;
         end
         StAddr1Data0: begin
            ahb_m_htrans_o = HTRANS_NONSEQ;
            ahb_m_haddr_o  = BASE_ADDR + DONE_OFS;
            ahb_m_hwdata_o = {27'b0, data_q};
         end
         StData1: begin
            ahb_m_hwdata_o = 32'h1;
         end
         default: ;
      endcase
   end

   assign ahb_m_hwrite_o    = (ahb_m_htrans_o == HTRANS_NONSEQ);
   assign ahb_m_hsize_o     = HSIZE_WORD;
   assign ahb_m_hburst_o    = HBURST_SINGLE;
   assign ahb_m_hprot_o     = HPROT_DATA;
   assign ahb_m_hmastlock_o = 1'b0;

   assign disp_value_o = disp_q;
   assign owner_o      = owner_q;
   assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_ssd_disp_sched.sv
// Directed bench for ssd_disp_sched with HOLD_CYCLES = 8.
module tb_ssd_disp_sched;

   localparam logic [31:0] Base = 32'hD000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  vld;
   logic [14:0] dat;
   logic [2:0]  rdy;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic        hready;
   logic [4:0]  disp;
   logic [1:0]  owner;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int beats = 0;
   int b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (htrans == 2'b10 && hready) beats <= beats + 1;
   end

   ssd_disp_sched #(
      .HOLD_CYCLES (8),
      .BASE_ADDR   (Base)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid_i       (vld),
      .req_data_i        (dat),
      .req_ready_o       (rdy),
      .ahb_m_haddr_o     (haddr),
      .ahb_m_htrans_o    (htrans),
      .ahb_m_hwrite_o    (hwrite),
      .ahb_m_hsize_o     (hsize),
      .ahb_m_hburst_o    (hburst),
      .ahb_m_hprot_o     (hprot),
      .ahb_m_hmastlock_o (hmastlock),
      .ahb_m_hwdata_o    (hwdata),
      .ahb_m_hready_i    (hready),
      .disp_value_o      (disp),
      .owner_o           (owner),
      .busy_o            (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in the first ADDR0 cycle with hready high; leaves in HOLD cycle 1.
   task automatic seq(input logic [4:0] v, input logic [1:0] own);
      chk("a0_owner", owner, own);
      chk("a0_htrans", htrans, 2'b10);
      chk("a0_haddr", haddr, Base);
      chk("a0_hwrite", hwrite, 1'b1);
      chk("a0_ready", rdy, 3'b000);
      chk("a0_busy", busy, 1'b1);
      tick();
      chk("a1_htrans", htrans, 2'b10);
      chk("a1_haddr", haddr, Base + 32'h4);
      chk("a1_hwdata", hwdata, {27'b0, v});
      chk("a1_ready", rdy, 3'b000);
      tick();
      chk("d1_htrans", htrans, 2'b00);
      chk("d1_haddr", haddr, Base);
      chk("d1_hwdata", hwdata, 32'h1);
      chk("d1_hwrite", hwrite, 1'b0);
      tick();
      chk("hold_disp", disp, {27'b0, v});
      chk("hold_busy0", busy, 1'b1);
      chk("hold_rdy0", rdy, 3'b000);
      chk("hold_htrans", htrans, 2'b00);
   endtask

   // Remaining seven HOLD cycles; the caller ticks once more into IDLE.
   task automatic hold_rest();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("hold_busy", busy, 1'b1);
         chk("hold_rdy", rdy, 3'b000);
      end
   endtask

   initial begin
      reset  = 1'b1;
      hready = 1'b1;
      vld    = 3'b001;
      dat    = '0;
      tick();
      tick();
      chk("rst_ready", rdy, 3'b000);
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_haddr", haddr, Base);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_disp", disp, 5'd0);
      chk("rst_owner", owner, 2'd3);
      chk("rst_busy", busy, 1'b0);
      chk("hsize", hsize, 3'b010);
      chk("hburst", hburst, 3'b000);
      chk("hprot", hprot, 4'b0011);
      chk("hmastlock", hmastlock, 1'b0);
      vld   = 3'b000;
      reset = 1'b0;
      tick();

      // Single request from requester 1.
      vld = 3'b010;
      dat = {5'd0, 5'd7, 5'd0};
      #1;
      chk("r1_ready", rdy, 3'b010);
      chk("r1_busy", busy, 1'b0);
      tick();
      vld = 3'b000;
      seq(5'd7, 2'd1);
      hold_rest();
      tick();
      chk("r1_idle", busy, 1'b0);
      chk("r1_owner_kept", owner, 2'd1);

      // All three request: served 0, 1, 2 in order.
      vld = 3'b111;
      dat = {5'd3, 5'd2, 5'd1};
      #1;
      chk("all_ready0", rdy, 3'b001);
      tick();
      vld = 3'b110;
      seq(5'd1, 2'd0);
      hold_rest();
      tick();
      chk("all_ready1", rdy, 3'b010);
      chk("all_idle1", busy, 1'b0);
      tick();
      vld = 3'b100;
      seq(5'd2, 2'd1);
      hold_rest();
      tick();
      chk("all_ready2", rdy, 3'b100);
      tick();
      vld = 3'b000;
      seq(5'd3, 2'd2);
      hold_rest();
      tick();
      chk("all_idle", busy, 1'b0);

      // Preemption of owner 2 in HOLD cycle 3, value above 23 kept as is.
      vld = 3'b100;
      dat = {5'd9, 5'd0, 5'd0};
      #1;
      chk("pre_ready2", rdy, 3'b100);
      tick();
      vld = 3'b000;
      seq(5'd9, 2'd2);
      tick();
      tick();
      vld = 3'b001;
      dat = {5'd0, 5'd0, 5'd25};
      #1;
      chk("pre_ready0", rdy, 3'b001);
      tick();
      vld = 3'b000;
      seq(5'd25, 2'd0);
      hold_rest();
      tick();
      chk("pre_idle", busy, 1'b0);

      // Lower-priority request waits out the whole hold of owner 1.
      vld = 3'b010;
      dat = {5'd6, 5'd4, 5'd0};
      #1;
      chk("wait_ready1", rdy, 3'b010);
      tick();
      vld = 3'b100;
      seq(5'd4, 2'd1);
      hold_rest();
      tick();
      chk("wait_ready2", rdy, 3'b100);
      chk("wait_idle", busy, 1'b0);
      tick();
      vld = 3'b000;
      seq(5'd6, 2'd2);
      hold_rest();
      tick();

      // Wait states in ADDR0 and DATA1.
      vld = 3'b001;
      dat = {5'd0, 5'd0, 5'd5};
      #1;
      chk("st_ready", rdy, 3'b001);
      b0 = beats;
      tick();
      vld    = 3'b000;
      hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("st_a0_htrans", htrans, 2'b10);
         chk("st_a0_haddr", haddr, Base);
         chk("st_a0_hwdata", hwdata, 32'h0);
         tick();
      end
      hready = 1'b1;
      #1;
      chk("st_a0_last", htrans, 2'b10);
      tick();
      chk("st_a1_hwdata", hwdata, 32'h5);
      chk("st_a1_haddr", haddr, Base + 32'h4);
      tick();
      hready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("st_d1_htrans", htrans, 2'b00);
         chk("st_d1_hwdata", hwdata, 32'h1);
         chk("st_d1_disp", disp, 5'd6);
         tick();
      end
      hready = 1'b1;
      #1;
      tick();
      chk("st_disp", disp, 5'd5);
      chk("st_beats", beats - b0, 2);
      hold_rest();
      tick();

      // Reset during ADDR1_DATA0 with the request held.
      vld = 3'b100;
      dat = {5'd11, 5'd0, 5'd0};
      #1;
      chk("rr_ready", rdy, 3'b100);
      tick();
      tick();
      chk("rr_a1_haddr", haddr, Base + 32'h4);
      reset = 1'b1;
      tick();
      #1;
      chk("rr_ready_in_rst", rdy, 3'b000);
      chk("rr_htrans", htrans, 2'b00);
      chk("rr_haddr", haddr, Base);
      chk("rr_hwdata", hwdata, 32'h0);
      chk("rr_disp", disp, 5'd0);
      chk("rr_owner", owner, 2'd3);
      chk("rr_busy", busy, 1'b0);
      reset = 1'b0;
      #1;
      chk("rr_regrant", rdy, 3'b100);
      tick();
      vld = 3'b000;
      seq(5'd11, 2'd2);
      hold_rest();
      tick();
      chk("rr_idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
